crc_frame_serializer: RTL and testbench
=======================================

Name: crc_frame_serializer

Overview:
- Upstream feeder for the serial CRC generator (crc_create).
- Accepts frame bytes over a valid/ready byte interface and emits them MSB-first as a bit stream to the downstream bit consumer.
- Drives the generator's init/enable/bit_in in lock-step with the emitted data bits, then latches the generator's CRC and appends it MSB-first.
- Marks the final frame bit with tx_last.

Parameters:
CRC_W, 8, width of the CRC field appended after data; must match crc_create output width.
MAX_BYTES, 8, data bytes per frame; the byte that reaches this count is treated as last regardless of s_last.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_data  in  8  frame byte
s_valid  in  1  s_data valid
s_last  in  1  s_data is final data byte of frame
s_ready  out  1  byte accepted when s_valid&&s_ready
tx_bit  out  1  serial output bit
tx_valid  out  1  tx_bit valid
tx_ready  in  1  consumer takes tx_bit this cycle (bit strobe)
tx_last  out  1  current bit is final CRC bit
crc_init  out  1  to crc_create.init
crc_en  out  1  to crc_create.enable
crc_bit  out  1  to crc_create.bit_in
crc_in  in  CRC_W  from crc_create.crc
busy  out  1  frame in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset (any cycle, including mid-frame): state=IDLE; holding register empty; tx_valid=0, tx_last=0, crc_init=0, crc_en=0, busy=0, s_ready=1. All outputs are registered or decoded from registered state only.
- Datapath registers:
  - 8-bit shift register plus its last flag.
  - One-entry holding register (hold_data, hold_last, hold_v).
  - 3-bit bit counter; byte counter sized clog2(MAX_BYTES+1).
  - CRC_W-bit CRC shift register; clog2(CRC_W) CRC bit counter.
- s_ready = !hold_v in IDLE/INIT/DATA/WAIT; 0 in LATCH/CRC. An accepted byte is written into the holding register. Effective last = s_last || (byte count reaches MAX_BYTES). Once a last byte is accepted, s_ready stays 0 until the frame completes.
- FSM states:
  - IDLE: busy=0. When hold_v is set, go to INIT.
  - INIT: exactly one cycle; crc_init=1; move hold into shifter, clear hold_v, bitcnt=0. Next state DATA.
  - DATA: tx_valid=1, tx_bit=shift[7], crc_bit=tx_bit, crc_en=tx_valid&&tx_ready. On an accepted bit, shift left and bitcnt++. On the accept with bitcnt==7:
    - if shifter last, go to LATCH;
    - else if hold_v, reload the shifter from hold and stay in DATA (no bubble);
    - else go to WAIT.
  - WAIT: underrun; tx_valid=0, crc_en=0. When hold_v is set, load the shifter and go to DATA.
  - LATCH: one cycle; tx_valid=0. crc_in is stable (updated at the final data-bit edge); capture it into the CRC shift register; crccnt=0. Next state CRC.
  - CRC: tx_valid=1, tx_bit=crcsh[CRC_W-1], crc_en=0, tx_last=(crccnt==CRC_W-1). On an accepted bit, shift and crccnt++. The accept of the last bit goes to IDLE.
- tx_valid held while tx_ready=0: tx_bit, crc_bit, tx_last stay stable; crc_en=0.
- Byte accept in the same cycle as a holding-register reload: the reload empties the register first, so s_ready is 1 only if hold_v is 0 at cycle start (no bypass).
- busy=1 in every state except IDLE.
- Frame of N bytes with tx_ready tied 1 and the holding register always full: 8N+CRC_W tx bits in 8N+CRC_W+2 cycles (INIT and LATCH are the only bubbles).

Decomposition:
- Package can_craft_pkg:
  - state enum ser_state_t {IDLE, INIT, DATA, WAIT, LATCH, CRC};
  - constant BYTE_W=8;
  - default CRC_W.
- No sub-module required. The holding register is inline.
- crc_create is instantiated by the parent alongside this block, not inside it.

Test Plan:
- Bench model: crc_in is driven by a behavioural model that returns 8'h5C once enabled bits have been seen.
- Single byte 0xA2 with s_last, tx_ready=1 → one crc_init pulse. Then tx bits 1,0,1,0,0,0,1,0 with crc_en=1 on each, then 0,1,0,1,1,1,0,0 with tx_last on the 16th bit. busy drops the cycle after.
- Two bytes 0x12, 0x34 back-to-back → 16 contiguous data bits with no gap, crc_en high for exactly 16 cycles. crc_init pulses exactly once per frame.
- tx_ready toggled 1-0-1 each cycle on byte 0xFF → crc_en pulses only on accept cycles (8 total). tx_bit stays stable during stalls.
- Underrun: byte 0x0F, then second byte 0xF0 presented 5 cycles late → WAIT with tx_valid=0 for those cycles. Bit sequence is unbroken 0x0F, 0xF0, then CRC.
- MAX_BYTES=2, three bytes offered with s_last never set → only 2 bytes accepted (s_ready=0 after the second), and the CRC follows.
- rst asserted during the third data bit → next cycle tx_valid=0, busy=0, s_ready=1. A new frame 0xA2 afterwards behaves as in the single-byte case.

Source files
------------

// File: rtl/can_craft_pkg.sv
// Shared types and constants for the CRC frame serializer.
package can_craft_pkg;

  // Width of one frame byte on the upstream interface.
  localparam int BYTE_W = 8;

  // Default CRC field width; must match the companion crc_create instance.
  localparam int DEFAULT_CRC_W = 8;

  // Serializer control states.
  //   IDLE  : no frame in progress
  //   INIT  : one-cycle generator init, first byte moves into the shifter
  //   DATA  : data bits go out MSB-first and feed the generator
  //   WAIT  : upstream underrun, nothing to send until the next byte arrives
  //   LATCH : one-cycle capture of the finished CRC
  //   CRC   : CRC bits go out MSB-first, the final one flagged with tx_last
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DATA,
    WAIT,
    LATCH,
    CRC
  } ser_state_t;

endpackage

// File: rtl/crc_frame_serializer.sv
// Byte-to-bit frame serializer that feeds a serial CRC generator in lock-step
// with the data bits, then appends the generator's CRC and marks the last bit.
module crc_frame_serializer
  import can_craft_pkg::*;
#(
  parameter int CRC_W     = DEFAULT_CRC_W,
  parameter int MAX_BYTES = 8
) (
  input  logic             clk,
  input  logic             rst,
  // Upstream byte interface
  input  logic [BYTE_W-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  // Downstream bit interface; tx_ready is a per-cycle take strobe
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  // Serial CRC generator hookup
  output logic             crc_init,
  output logic             crc_en,
  output logic             crc_bit,
  input  logic [CRC_W-1:0] crc_in,
  // Status
  output logic             busy
);

  localparam int BIT_CNT_W  = $clog2(BYTE_W);
  localparam int BYTE_CNT_W = $clog2(MAX_BYTES + 1);
  localparam int CRC_CNT_W  = (CRC_W > 1) ? $clog2(CRC_W) : 1;

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BYTE_W - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(MAX_BYTES - 1);
  localparam logic [CRC_CNT_W-1:0]  LAST_CRC  = CRC_CNT_W'(CRC_W - 1);

  ser_state_t state, state_nxt;

  // Bit shifter and the last-byte flag travelling with its byte
  logic [BYTE_W-1:0]     shift_q;
  logic                  shift_last;
  logic [BIT_CNT_W-1:0]  bitcnt;

  // One-entry holding register between the byte port and the shifter
  logic [BYTE_W-1:0]     hold_data;
  logic                  hold_last;
  logic                  hold_v;

  // Frame byte accounting; last_taken closes the byte port until frame end
  logic [BYTE_CNT_W-1:0] bytecnt;
  logic                  last_taken;

  // CRC capture and its bit counter
  logic [CRC_W-1:0]      crcsh;
  logic [CRC_CNT_W-1:0]  crccnt;

  // Decoded events
  logic byte_acc;    // upstream byte written into the holding register
  logic eff_last;    // accepted byte closes the frame
  logic data_acc;    // data bit taken downstream
  logic crc_acc;     // CRC bit taken downstream
  logic byte_end;    // final bit of the current data byte taken
  logic crc_end;     // final CRC bit taken
  logic load_shift;  // holding register moves into the shifter
  logic room;        // holding register may accept a byte

  assign room       = !hold_v && !last_taken;
  assign byte_acc   = s_valid && s_ready;
  assign eff_last   = s_last || (bytecnt == LAST_BYTE);
  assign data_acc   = (state == DATA) && tx_ready;
  assign crc_acc    = (state == CRC) && tx_ready;
  assign byte_end   = data_acc && (bitcnt == LAST_BIT);
  assign crc_end    = crc_acc && (crccnt == LAST_CRC);
  assign load_shift = (state == INIT)
                   || (byte_end && !shift_last && hold_v)
                   || ((state == WAIT) && hold_v);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values, independent of block evaluation order.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt;
    // an unassigned path would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:  if (hold_v) state_nxt = INIT;
      INIT:  state_nxt = DATA;
      DATA: begin
        if (byte_end) begin
          if (shift_last)   state_nxt = LATCH;
          else if (!hold_v) state_nxt = WAIT;
        end
      end
      WAIT:  if (hold_v) state_nxt = DATA;
      LATCH: state_nxt = CRC;
      CRC:   if (crc_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    s_ready  = 1'b0;
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    tx_last  = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_bit  = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE, WAIT: s_ready = room;
      INIT: begin
        s_ready  = room;
        crc_init = 1'b1;
      end
      DATA: begin
        s_ready  = room;
        tx_valid = 1'b1;
        tx_bit   = shift_q[BYTE_W-1];
        crc_bit  = shift_q[BYTE_W-1];
        crc_en   = tx_ready;
      end
      CRC: begin
        tx_valid = 1'b1;
        tx_bit   = crcsh[CRC_W-1];
        tx_last  = (crccnt == LAST_CRC);
      end
      default: ;
    endcase
  end

  // Holding-register occupancy and frame byte accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v     <= 1'b0;
      last_taken <= 1'b0;
      bytecnt    <= '0;
    end else begin
      if (byte_acc) begin
        hold_v  <= 1'b1;
        bytecnt <= bytecnt + 1'b1;
        if (eff_last) last_taken <= 1'b1;
      end else if (load_shift) begin
        hold_v <= 1'b0;
      end
      if (crc_end) begin
        last_taken <= 1'b0;
        bytecnt    <= '0;
      end
    end
  end

  // Holding-register payload
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; they are always written before
    // being observed because outputs are gated by the reset-cleared state.
    if (byte_acc) begin
      hold_data <= s_data;
      hold_last <= eff_last;
    end
  end

  // Data shifter with bit counter, and CRC capture/shift with its counter
  always_ff @(posedge clk) begin
    if (load_shift) begin
      shift_q    <= hold_data;
      shift_last <= hold_last;
      bitcnt     <= '0;
    end else if (data_acc) begin
      shift_q <= shift_q << 1;
      bitcnt  <= bitcnt + 1'b1;
    end

    if (state == LATCH) begin
      crcsh  <= crc_in;
      crccnt <= '0;
    end else if (crc_acc) begin
      crcsh  <= crcsh << 1;
      crccnt <= crccnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Self-checking bench for crc_frame_serializer. Two instances share stimulus:
// u_dut (MAX_BYTES=8) and u_dut_m2 (MAX_BYTES=2); sel picks the active one and
// holds the other in reset. A behavioural stand-in for crc_create returns
// 8'h5C once enabled bits have been seen since init.
module tb_crc_frame_serializer;

  localparam int CW = 8;
  localparam logic [CW-1:0] CRC_CONST = 8'h5C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sel;
  logic [7:0]    s_data;
  logic          s_valid, s_last, tx_ready;
  logic [CW-1:0] crc_in;

  logic a_s_ready, a_tx_bit, a_tx_valid, a_tx_last, a_crc_init, a_crc_en, a_crc_bit, a_busy;
  logic b_s_ready, b_tx_bit, b_tx_valid, b_tx_last, b_crc_init, b_crc_en, b_crc_bit, b_busy;
  logic s_ready, tx_bit, tx_valid, tx_last, crc_init, crc_en, crc_bit, busy;
  logic rst_a, rst_b, s_valid_a, s_valid_b, tx_ready_a, tx_ready_b;

  assign rst_a      = rst | sel;
  assign rst_b      = rst | ~sel;
  assign s_valid_a  = s_valid & ~sel;
  assign s_valid_b  = s_valid & sel;
  assign tx_ready_a = tx_ready & ~sel;
  assign tx_ready_b = tx_ready & sel;

  crc_frame_serializer #(.CRC_W(CW), .MAX_BYTES(8)) u_dut (
    .clk(clk), .rst(rst_a), .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last),
    .s_ready(a_s_ready), .tx_bit(a_tx_bit), .tx_valid(a_tx_valid), .tx_ready(tx_ready_a),
    .tx_last(a_tx_last), .crc_init(a_crc_init), .crc_en(a_crc_en), .crc_bit(a_crc_bit),
    .crc_in(crc_in), .busy(a_busy));

  crc_frame_serializer #(.CRC_W(CW), .MAX_BYTES(2)) u_dut_m2 (
    .clk(clk), .rst(rst_b), .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last),
    .s_ready(b_s_ready), .tx_bit(b_tx_bit), .tx_valid(b_tx_valid), .tx_ready(tx_ready_b),
    .tx_last(b_tx_last), .crc_init(b_crc_init), .crc_en(b_crc_en), .crc_bit(b_crc_bit),
    .crc_in(crc_in), .busy(b_busy));

  assign s_ready  = sel ? b_s_ready  : a_s_ready;
  assign tx_bit   = sel ? b_tx_bit   : a_tx_bit;
  assign tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign tx_last  = sel ? b_tx_last  : a_tx_last;
  assign crc_init = sel ? b_crc_init : a_crc_init;
  assign crc_en   = sel ? b_crc_en   : a_crc_en;
  assign crc_bit  = sel ? b_crc_bit  : a_crc_bit;
  assign busy     = sel ? b_busy     : a_busy;

  // Behavioural crc_create stand-in
  always @(posedge clk) begin
    if (rst || crc_init) crc_in <= '0;
    else if (crc_en)     crc_in <= CRC_CONST;
  end

  // Bookkeeping
  int checks, failures;
  int ready_mode;            // 0: always ready, 1: toggle, 2: random
  bit mon_on;
  int n_exp;
  logic [7:0] frm_bytes[$];
  int         gaps[$];
  logic       exp_bits[$];
  logic       got_bits[$];
  logic       got_last[$];
  logic [7:0] acc_bytes[$];
  int init_cnt, en_cnt, busy_cyc, bubble_cyc;
  logic prev_stall, prev_bit, prev_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream ready pattern, changed just after each edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (mon_on) begin
      if (crc_init) init_cnt++;
      if (crc_en)   en_cnt++;
      if (busy)     busy_cyc++;
      if (busy && !tx_valid) bubble_cyc++;
      if (prev_stall) begin
        check("stall_valid", tx_valid, 1'b1);
        check("stall_bit", tx_bit, prev_bit);
        check("stall_last", tx_last, prev_last);
      end
      check("crc_en_strobe", crc_en,
            tx_valid && tx_ready && (got_bits.size() < 8 * n_exp));
      if (tx_valid && tx_ready) begin
        if (got_bits.size() < 8 * n_exp) check("crc_bit_follow", crc_bit, tx_bit);
        got_bits.push_back(tx_bit);
        got_last.push_back(tx_last);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_bit   = tx_bit;
      prev_last  = tx_last;
      if (s_valid && s_ready) acc_bytes.push_back(s_data);
    end
  end

  // Offer frm_bytes; indices >= n_acc are expected to be refused
  task automatic drive_bytes(input int n_acc, input bit use_last);
    int t;
    for (int i = 0; i < frm_bytes.size(); i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        @(posedge clk); #1;
      end
      s_data  = frm_bytes[i];
      s_last  = use_last && (i == frm_bytes.size() - 1);
      s_valid = 1'b1;
      if (i < n_acc) begin
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 500) begin
          @(negedge clk);
          t++;
        end
        check("byte_accept", s_ready, 1'b1);
      end else begin
        for (int k = 0; k < 15; k++) begin
          @(negedge clk);
          check("refuse_after_last", s_ready, 1'b0);
        end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // Run one frame against the reference bit stream. abort_bits >= 0 stops
  // after that many accepted bits (mid-frame reset case).
  task automatic run_frame(input string name, input int n_acc, input bit use_last,
                           input int abort_bits, input int exp_busy, input int exp_bubble);
    logic [CW-1:0] crc_v;
    logic [7:0]    byte_v;
    int target, t, nbad, nlast, nacc;
    crc_v = CRC_CONST;
    exp_bits.delete();
    for (int i = 0; i < n_acc; i++) begin
      byte_v = frm_bytes[i];
      for (int b = 7; b >= 0; b--) exp_bits.push_back(byte_v[b]);
    end
    for (int b = CW - 1; b >= 0; b--) exp_bits.push_back(crc_v[b]);
    got_bits.delete(); got_last.delete(); acc_bytes.delete();
    init_cnt = 0; en_cnt = 0; busy_cyc = 0; bubble_cyc = 0;
    prev_stall = 1'b0; n_exp = n_acc;
    target = (abort_bits >= 0) ? abort_bits : exp_bits.size();
    mon_on = 1'b1;
    fork
      drive_bytes(n_acc, use_last);
      begin
        t = 0;
        while (got_bits.size() < target && t < 3000) begin
          @(posedge clk);
          t++;
        end
      end
    join
    check({name, "/progress"}, got_bits.size(), target);
    if (abort_bits < 0) begin
      @(negedge clk);
      check({name, "/end_busy"}, busy, 1'b0);
      check({name, "/end_tx_valid"}, tx_valid, 1'b0);
      check({name, "/end_s_ready"}, s_ready, 1'b1);
      mon_on = 1'b0;
      nbad = 0; nlast = 0;
      for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++) begin
        if (got_bits[i] !== exp_bits[i]) nbad++;
        if (got_last[i] !== (i == exp_bits.size() - 1)) nlast++;
      end
      check({name, "/bit_count"}, got_bits.size(), exp_bits.size());
      check({name, "/bit_errors"}, nbad, 0);
      check({name, "/tx_last_errors"}, nlast, 0);
      check({name, "/crc_en_count"}, en_cnt, 8 * n_acc);
      check({name, "/crc_init_count"}, init_cnt, 1);
      nacc = 0;
      for (int i = 0; i < acc_bytes.size() && i < n_acc; i++)
        if (acc_bytes[i] !== frm_bytes[i]) nacc++;
      check({name, "/bytes_taken"}, acc_bytes.size(), n_acc);
      check({name, "/byte_errors"}, nacc, 0);
      if (exp_busy >= 0)   check({name, "/busy_cycles"}, busy_cyc, exp_busy);
      if (exp_bubble >= 0) check({name, "/bubble_cycles"}, bubble_cyc, exp_bubble);
    end else begin
      mon_on = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ul;
    checks = 0; failures = 0; mon_on = 1'b0; n_exp = 0;
    sel = 1'b0; ready_mode = 0; tx_ready = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; rst = 1'b1;
    prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
    idle(3);

    // Reset state
    @(negedge clk);
    check("reset/tx_valid", tx_valid, 1'b0);
    check("reset/tx_last", tx_last, 1'b0);
    check("reset/crc_init", crc_init, 1'b0);
    check("reset/crc_en", crc_en, 1'b0);
    check("reset/busy", busy, 1'b0);
    check("reset/s_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Single byte 0xA2: 18 busy cycles, INIT and LATCH the only bubbles
    frm_bytes = '{8'hA2}; gaps = '{0};
    run_frame("single", 1, 1'b1, -1, 18, 2);
    idle(3);

    // Two bytes back-to-back: no gap between bytes
    frm_bytes = '{8'h12, 8'h34}; gaps = '{0, 0};
    run_frame("b2b", 2, 1'b1, -1, 26, 2);
    idle(3);

    // Downstream toggling ready on 0xFF
    ready_mode = 1;
    frm_bytes = '{8'hFF}; gaps = '{0};
    run_frame("toggle", 1, 1'b1, -1, -1, -1);
    ready_mode = 0;
    idle(3);

    // Underrun: second byte late enough for five WAIT cycles
    frm_bytes = '{8'h0F, 8'hF0}; gaps = '{0, 13};
    run_frame("underrun", 2, 1'b1, -1, 31, 7);
    idle(3);

    // MAX_BYTES=2 instance: third byte refused, CRC follows the second
    sel = 1'b1;
    idle(2);
    frm_bytes = '{8'h3C, 8'hC3, 8'h99}; gaps = '{0, 0, 0};
    run_frame("max2", 2, 1'b0, -1, 26, 2);
    idle(3);
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 2);
      ul = (n < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      ready_mode = $urandom_range(0, 2);
      frm_bytes.delete(); gaps.delete();
      for (int i = 0; i < n; i++) begin
        frm_bytes.push_back(8'($urandom));
        gaps.push_back($urandom_range(0, 3));
      end
      run_frame("max2_rand", n, ul, -1, -1, -1);
      idle(2);
    end
    ready_mode = 0;
    sel = 1'b0;
    idle(2);

    // Reset while the third data bit is on the line
    frm_bytes = '{8'hA2}; gaps = '{0};
    run_frame("abort", 1, 1'b1, 2, -1, -1);
    #1;
    check("abort/mid_tx_valid", tx_valid, 1'b1);
    check("abort/mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/tx_valid", tx_valid, 1'b0);
    check("rst_mid/busy", busy, 1'b0);
    check("rst_mid/s_ready", s_ready, 1'b1);
    check("rst_mid/crc_en", crc_en, 1'b0);
    idle(2);
    frm_bytes = '{8'hA2}; gaps = '{0};
    run_frame("after_rst", 1, 1'b1, -1, 18, 2);
    idle(3);

    // Randomized frames on the MAX_BYTES=8 instance
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 8);
      ul = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      ready_mode = $urandom_range(0, 2);
      frm_bytes.delete(); gaps.delete();
      for (int i = 0; i < n; i++) begin
        frm_bytes.push_back(8'($urandom));
        gaps.push_back($urandom_range(0, 3));
      end
      run_frame("rand", n, ul, -1, -1, -1);
      idle($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
